// File: rtl/game_ctrl_pkg.sv
// Shared match encodings for game_ctrl and the display path: states, winner codes, default target score.
// Pure declarations, no logic.
package game_ctrl_pkg;

  localparam int TMR_W = 26;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } gc_state_e;

  localparam logic [3:0] WIN_SCORE_DEF = 4'd7;
  localparam logic [3:0] SCORE_MAX     = 4'hF;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == SCORE_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_ctrl_gc_timer.sv
// gc_timer: 26-bit down-counter; done pulses in the load_val-th cycle after load.
// No backpressure; a new load restarts the count.
module gc_timer
  import game_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count parks at zero, so this fires exactly once per load.
  assign done = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: pong match sequencer (IDLE/SERVE/PLAY/POINT/OVER); outputs registered, s is combinational.
// No backpressure; pulses outside their state are dropped. GAME_SPEEDUP_EN adds the rally speed-up flag.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned SERVE_CYC = 25_000_000,
  parameter int unsigned POINT_CYC = 50_000_000,
  parameter logic [3:0]  WIN_SCORE = WIN_SCORE_DEF,
  parameter logic [7:0]  RALLY_TH  = 8'd6
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       speed_sw,
  input  logic       hit,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       guiwei,
  output logic       s,
  output logic       ball_en,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [TMR_W-1:0] SERVE_LD = TMR_W'(SERVE_CYC);
  localparam logic [TMR_W-1:0] POINT_LD = TMR_W'(POINT_CYC);

  gc_state_e        state_q, state_d;
  logic             guiwei_q, guiwei_d;
  logic             ball_en_q, ball_en_d;
  logic             serve_dir_q, serve_dir_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic [1:0]       winner_q, winner_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  gc_timer u_timer (
    .clk      (vga_clk),
    .rst_n    (sys_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    serve_dir_d = serve_dir_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = WIN_NONE;
          serve_dir_d = 1'b1;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: if (tmr_done) state_d = ST_PLAY;
      ST_PLAY: begin
        // A double miss is a dead ball: freeze without awarding anyone.
        if (miss_l || miss_r) begin
          state_d = ST_POINT;
          if (miss_l && !miss_r) begin
            score_r_d   = sat_inc4(score_r_q);
            serve_dir_d = 1'b0;
          end else if (miss_r && !miss_l) begin
            score_l_d   = sat_inc4(score_l_q);
            serve_dir_d = 1'b1;
          end
        end
      end
      ST_POINT: begin
        if (tmr_done) begin
          if (score_l_q == WIN_SCORE) begin
            state_d  = ST_OVER;
            winner_d = WIN_LEFT;
          end else if (score_r_q == WIN_SCORE) begin
            state_d  = ST_OVER;
            winner_d = WIN_RIGHT;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tmr_load  = (state_d != state_q) && ((state_d == ST_SERVE) || (state_d == ST_POINT));
    tmr_val   = (state_d == ST_POINT) ? POINT_LD : SERVE_LD;
    guiwei_d  = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    ball_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      guiwei_q    <= 1'b0;
      ball_en_q   <= 1'b0;
      serve_dir_q <= 1'b1;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      guiwei_q    <= guiwei_d;
      ball_en_q   <= ball_en_d;
      serve_dir_q <= serve_dir_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
    end
  end

`ifdef GAME_SPEEDUP_EN
  logic [7:0] rally_cnt_q, rally_cnt_d;
  logic       rally_flag_q, rally_flag_d;

  always_comb begin
    rally_cnt_d  = rally_cnt_q;
    rally_flag_d = rally_flag_q;
    if ((state_q == ST_PLAY) && hit && (rally_cnt_q != 8'hFF)) begin
      rally_cnt_d = rally_cnt_q + 8'd1;
    end
    if ((state_q == ST_PLAY) && (rally_cnt_d >= RALLY_TH)) begin
      rally_flag_d = 1'b1;
    end
    if (guiwei_d) begin
      rally_cnt_d  = 8'd0;
      rally_flag_d = 1'b0;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rally_cnt_q  <= 8'd0;
      rally_flag_q <= 1'b0;
    end else begin
      rally_cnt_q  <= rally_cnt_d;
      rally_flag_q <= rally_flag_d;
    end
  end

  assign s = speed_sw | rally_flag_q;
`else
  logic unused_rally;
  assign unused_rally = ^{hit, RALLY_TH};
  assign s = speed_sw;
`endif

  assign guiwei    = guiwei_q;
  assign ball_en   = ball_en_q;
  assign serve_dir = serve_dir_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: rule-level model checked every cycle, plus directed literal checks.
module tb_game_ctrl;

  localparam int SC = 4;
  localparam int PC = 3;
  localparam int WS = 2;
  localparam int TH = 2;
`ifdef GAME_SPEEDUP_EN
  localparam int SPD = 1;
`else
  localparam int SPD = 0;
`endif

  logic       vga_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       start = 1'b0, speed_sw = 1'b0, hit = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic       guiwei, s, ball_en, serve_dir;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] state;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  game_ctrl #(
    .SERVE_CYC (SC),
    .POINT_CYC (PC),
    .WIN_SCORE (4'(WS)),
    .RALLY_TH  (8'(TH))
  ) dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .speed_sw  (speed_sw),
    .hit       (hit),
    .miss_l    (miss_l),
    .miss_r    (miss_r),
    .guiwei    (guiwei),
    .s         (s),
    .ball_en   (ball_en),
    .serve_dir (serve_dir),
    .score_l   (score_l),
    .score_r   (score_r),
    .winner    (winner),
    .state     (state)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Match model: state name, cycles spent in it so far, and the rule outcomes.
  int m_st = 0, m_dwell = 0, m_sl = 0, m_sr = 0, m_dir = 1, m_win = 0, m_hits = 0;
  int m_gw = 0, m_flag = 0;

  always @(posedge vga_clk or negedge sys_rst_n) begin : model
    int nx;
    if (!sys_rst_n) begin
      m_st = 0; m_dwell = 0; m_sl = 0; m_sr = 0; m_dir = 1; m_win = 0;
      m_hits = 0; m_gw = 0; m_flag = 0;
    end else begin
      nx = m_st;
      case (m_st)
        0, 4: if (start) begin
          m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1; nx = 1;
        end
        1: if (m_dwell == SC) nx = 2;
        2: begin
          if (hit) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
          if (m_hits >= TH) m_flag = 1;
          if (miss_l || miss_r) begin
            nx = 3;
            if (miss_l && !miss_r) begin m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_dir = 0; end
            if (miss_r && !miss_l) begin m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_dir = 1; end
          end
        end
        3: if (m_dwell == PC) begin
          if (m_sl == WS) begin nx = 4; m_win = 1; end
          else if (m_sr == WS) begin nx = 4; m_win = 2; end
          else nx = 1;
        end
        default: nx = 0;
      endcase
      m_gw = (nx == 1 && m_st != 1) ? 1 : 0;
      if (m_gw == 1) begin m_hits = 0; m_flag = 0; end
      m_dwell = (nx != m_st) ? 1 : m_dwell + 1;
      m_st = nx;
    end
  end

  always @(negedge vga_clk) begin
    if (chk_en) begin
      check("cyc_state", int'(state), m_st);
      check("cyc_guiwei", int'(guiwei), m_gw);
      check("cyc_ball_en", int'(ball_en), (m_st == 2) ? 1 : 0);
      check("cyc_serve_dir", int'(serve_dir), m_dir);
      check("cyc_score_l", int'(score_l), m_sl);
      check("cyc_score_r", int'(score_r), m_sr);
      check("cyc_winner", int'(winner), m_win);
      check("cyc_s", int'(s), int'(speed_sw) | (SPD & m_flag));
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Counts consecutive cycles spent in st starting from the current one.
  task automatic dwell(input logic [2:0] st, input string nm, input int exp_n);
    int n = 0;
    while (state == st && n < 50) begin
      n++;
      tick();
    end
    check(nm, n, exp_n);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not finish, compared %0d", compared);
    $fatal(1);
  end

  initial begin
    #2 sys_rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #19 sys_rst_n = 1'b1;
    tick();
    check("rst_state", int'(state), 0);
    check("rst_serve_dir", int'(serve_dir), 1);
    check("rst_ball_en", int'(ball_en), 0);
    check("rst_winner", int'(winner), 0);

    // Reset then start
    start = 1'b1; tick(); start = 1'b0;
    check("start_guiwei", int'(guiwei), 1);
    check("start_state", int'(state), 1);
    dwell(3'd1, "serve_len", 4);
    check("play_state", int'(state), 2);
    check("play_ball_en", int'(ball_en), 1);
    check("play_guiwei", int'(guiwei), 0);

    // Single miss_r
    miss_r = 1'b1; tick(); miss_r = 1'b0;
    check("miss_r_state", int'(state), 3);
    check("miss_r_score_l", int'(score_l), 1);
    check("miss_r_dir", int'(serve_dir), 1);
    check("miss_r_ball_en", int'(ball_en), 0);
    dwell(3'd3, "point_len", 3);
    check("reserve_guiwei", int'(guiwei), 1);
    start = 1'b1; hit = 1'b1; tick(); start = 1'b0; hit = 1'b0;
    dwell(3'd1, "serve_len2", 3);

    // Simultaneous misses
    miss_l = 1'b1; miss_r = 1'b1; tick(); miss_l = 1'b0; miss_r = 1'b0;
    check("dbl_state", int'(state), 3);
    check("dbl_score_l", int'(score_l), 1);
    check("dbl_score_r", int'(score_r), 0);
    check("dbl_dir", int'(serve_dir), 1);
    dwell(3'd3, "dbl_point_len", 3);
    dwell(3'd1, "dbl_serve_len", 4);

    // Speed-up by rally hits, and the speed switch itself
    check("pre_hit_s", int'(s), 0);
    hit = 1'b1; tick(); tick(); hit = 1'b0;
    check("rally_s", int'(s), SPD);
    speed_sw = 1'b1; #1;
    check("speed_sw_s", int'(s), 1);
    speed_sw = 1'b0; tick();

    // Match to completion with two left misses
    miss_l = 1'b1; tick(); miss_l = 1'b0;
    check("ml1_score_r", int'(score_r), 1);
    check("ml1_dir", int'(serve_dir), 0);
    dwell(3'd3, "ml1_point_len", 3);
    check("serve_s_clear", int'(s), 0);
    dwell(3'd1, "ml1_serve_len", 4);
    miss_l = 1'b1; tick(); miss_l = 1'b0;
    check("ml2_score_r", int'(score_r), 2);
    dwell(3'd3, "ml2_point_len", 3);
    check("over_state", int'(state), 4);
    check("over_winner", int'(winner), 2);
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    check("restart_state", int'(state), 1);
    check("restart_score_r", int'(score_r), 0);
    check("restart_winner", int'(winner), 0);
    check("restart_dir", int'(serve_dir), 1);
    dwell(3'd1, "restart_serve_len", 4);

    // Asynchronous reset mid-PLAY
    miss_r = 1'b1; tick(); miss_r = 1'b0;
    dwell(3'd3, "pre_rst_point", 3);
    dwell(3'd1, "pre_rst_serve", 4);
    check("pre_rst_score_l", int'(score_l), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_score_l", int'(score_l), 0);
    check("arst_ball_en", int'(ball_en), 0);
    check("arst_dir", int'(serve_dir), 1);
    check("arst_guiwei", int'(guiwei), 0);
    #10 sys_rst_n = 1'b1;
    tick(); tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
